dmem_mmio_responder: RTL

- Responder end of the core's data-memory interface: accepts the address, write data and byte-write mask issued in the execute stage, and returns read data to the memory stage one cycle later.
- Decodes the address into three regions:
  - a synchronous data RAM;
  - a memory-mapped I/O (MMIO) window holding the UART byte-stream registers and cycle/instruction counters;
  - unmapped space.
- Owns a small TX byte FIFO that decouples core stores from the UART transmitter.

---
 rtl/dmem_mmio_responder_if.sv | 32 +++
 rtl/dmem_mmio_responder.sv | 132 +++++++++++++
 2 files changed

// File: rtl/dmem_mmio_responder_if.sv
`default_nettype none
// ============================================================================
// Module      : dmem_mmio_responder_if
// Description : Data-memory bus and UART byte-stream signals between the core
//               side and the dmem/MMIO responder.
// Revision    : 1.0 - initial release
// ============================================================================
interface dmem_mmio_responder_if;
    logic [31:0] mem_adr;
    logic [31:0] mem_wdata;
    logic [3:0]  wea;
    logic        re;
    logic [31:0] din;
    logic        instr_retired;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        rx_ready;

    modport slave (
        input  mem_adr, mem_wdata, wea, re, instr_retired, tx_ready, rx_data, rx_valid,
        output din, tx_data, tx_valid, rx_ready
    );

    modport master (
        output mem_adr, mem_wdata, wea, re, instr_retired, tx_ready, rx_data, rx_valid,
        input  din, tx_data, tx_valid, rx_ready
    );
endinterface
`default_nettype wire

// File: rtl/dmem_mmio_responder.sv
`default_nettype none
// ============================================================================
// Module      : dmem_mmio_responder
// Description : Data RAM + MMIO (UART stream, cycle/instret counters) responder
//               with one-cycle registered read data and a small TX byte FIFO.
// Revision    : 1.0 - initial release
// ============================================================================
module dmem_mmio_responder #(
    parameter int DMEM_AW   = 12,
    parameter int TXF_DEPTH = 4
) (
    input  wire logic             clk,
    input  wire logic             reset_n,
    dmem_mmio_responder_if.slave  bus
);
    localparam int              c_ptr_w      = $clog2(TXF_DEPTH);
    localparam logic [c_ptr_w:0] c_depth     = (c_ptr_w + 1)'(TXF_DEPTH);
    localparam logic [3:0]      c_rgn_ram    = 4'h1;
    localparam logic [3:0]      c_rgn_mmio   = 4'h8;
    localparam logic [5:0]      c_off_status = 6'h00;
    localparam logic [5:0]      c_off_rx     = 6'h01;
    localparam logic [5:0]      c_off_tx     = 6'h02;
    localparam logic [5:0]      c_off_cyc    = 6'h04;
    localparam logic [5:0]      c_off_ins    = 6'h05;
    localparam logic [5:0]      c_off_clr    = 6'h06;

    logic                w_is_ram;
    logic                w_is_mmio;
    logic [5:0]          w_off;
    logic [DMEM_AW-1:0]  w_ram_idx;
    logic [31:0]         w_mmio_rdata;
    logic                w_push;
    logic                w_pop;
    logic                w_push_ok;
    logic                w_full;
    logic                w_cnt_clr;
    logic [c_ptr_w:0]    w_count;
    logic                w_unused_bits;

    logic [31:0]         r_ram [2**DMEM_AW];
    logic [31:0]         r_ram_q;
    logic                r_sel_ram;
    logic [31:0]         r_mmio_q;
    logic [7:0]          r_fifo [TXF_DEPTH];
    logic [c_ptr_w:0]    r_wptr;
    logic [c_ptr_w:0]    r_rptr;
    logic [31:0]         r_cyc_cnt;
    logic [31:0]         r_ins_cnt;

    // Low two address bits never take part in decode (misaligned accesses alias).
    assign w_is_ram      = (bus.mem_adr[31:28] == c_rgn_ram);
    assign w_is_mmio     = (bus.mem_adr[31:28] == c_rgn_mmio);
    assign w_off         = bus.mem_adr[7:2];
    assign w_ram_idx     = bus.mem_adr[DMEM_AW+1:2];
    assign w_unused_bits = ^{bus.mem_adr[27:DMEM_AW+2], bus.mem_adr[1:0]};

    assign w_count   = r_wptr - r_rptr;
    assign w_full    = (w_count == c_depth);
    assign w_pop     = bus.tx_valid & bus.tx_ready;
    assign w_push    = w_is_mmio & (w_off == c_off_tx) & bus.wea[0];
    // A pop in the same cycle frees the slot, so a push into a full FIFO is kept.
    assign w_push_ok = w_push & (~w_full | w_pop);
    assign w_cnt_clr = w_is_mmio & (w_off == c_off_clr) & (|bus.wea);

    assign bus.tx_valid = (w_count != '0);
    assign bus.tx_data  = r_fifo[r_rptr[c_ptr_w-1:0]];
    assign bus.rx_ready = reset_n & w_is_mmio & (w_off == c_off_rx) & bus.re & bus.rx_valid;
    assign bus.din      = r_sel_ram ? r_ram_q : r_mmio_q;

    always_comb begin
        w_mmio_rdata = '0;
        if (w_is_mmio) begin
            case (w_off)
                c_off_status: w_mmio_rdata = {30'b0, bus.rx_valid, ~w_full};
                c_off_rx:     w_mmio_rdata = bus.rx_valid ? {24'b0, bus.rx_data} : 32'b0;
                c_off_cyc:    w_mmio_rdata = r_cyc_cnt;
                c_off_ins:    w_mmio_rdata = r_ins_cnt;
                default:      w_mmio_rdata = '0;
            endcase
        end
    end

    // RAM array: no reset; non-blocking read gives read-first on collisions.
    always_ff @(posedge clk) begin
        r_ram_q <= r_ram[w_ram_idx];
        for (int i = 0; i < 4; i++) begin
            if (w_is_ram && bus.wea[i]) begin
                r_ram[w_ram_idx][8*i +: 8] <= bus.mem_wdata[8*i +: 8];
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_sel_ram <= 1'b0;
            r_mmio_q  <= '0;
        end else begin
            r_sel_ram <= w_is_ram;
            r_mmio_q  <= w_mmio_rdata;
        end
    end

    always_ff @(posedge clk) begin
        if (w_push_ok) begin
            r_fifo[r_wptr[c_ptr_w-1:0]] <= bus.mem_wdata[7:0];
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_wptr <= '0;
            r_rptr <= '0;
        end else begin
            if (w_push_ok) r_wptr <= r_wptr + 1'b1;
            if (w_pop)     r_rptr <= r_rptr + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_cyc_cnt <= '0;
            r_ins_cnt <= '0;
        end else if (w_cnt_clr) begin
            r_cyc_cnt <= '0;
            r_ins_cnt <= '0;
        end else begin
            r_cyc_cnt <= r_cyc_cnt + 32'd1;
            r_ins_cnt <= r_ins_cnt + {31'b0, bus.instr_retired};
        end
    end
endmodule
`default_nettype wire
